// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: memory word widths, decoder next_pc_src encodings,
// fetch FSM states and the fetch queue entry layout.
package instruction_fetch_pkg;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned IMEM_WORD_WIDTH = 32;
  localparam logic [ADDR_WIDTH-1:0] INSTR_BYTES = 32'd4;

  // Decoder next_pc_src encodings
  localparam logic [1:0] NEXT_PC_SRC_ALWAYS_NOT_BRANCH                = 2'b00;
  localparam logic [1:0] NEXT_PC_SRC_ALWAYS_BRANCH                    = 2'b01;
  localparam logic [1:0] NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO     = 2'b10;
  localparam logic [1:0] NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_NOT_ZERO = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      pc;
    logic [IMEM_WORD_WIDTH-1:0] instr;
  } fq_entry_t;

  function automatic logic redirect_taken(input logic [1:0] src, input logic zero);
    logic taken;
    case (src)
      NEXT_PC_SRC_ALWAYS_BRANCH:                    taken = 1'b1;
      NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO:     taken = zero;
      NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_NOT_ZERO: taken = ~zero;
      default:                                      taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Small synchronous FIFO of {pc, instruction} pairs; flush has priority over push/pop.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fq_entry_t                push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output fq_entry_t                head,
  output logic [$clog2(FQ_DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  fq_entry_t        mem_q [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok, push_ok;

  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != DEPTH_C) || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one-outstanding-request memory front end, fetch queue toward the decoder,
// and redirect handling for branches/jumps resolved in execute.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready,
  input  logic        resolve_valid,
  input  logic [1:0]  next_pc_src,
  input  logic        alu_pc_result_zero,
  input  logic [31:0] alu_pc_target
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic             drop_q, drop_d;
  logic             taken, resp_fire, push, pop;
  logic [31:0]      target_aligned;
  logic [CNT_W-1:0] count;
  fq_entry_t        head;

  assign taken          = resolve_valid && redirect_taken(next_pc_src, alu_pc_result_zero);
  assign target_aligned = alu_pc_target & ~32'd3;
  assign resp_fire      = imem_resp_valid && (state_q == StWait);

  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    req_addr_d     = req_addr_q;
    drop_d         = drop_q;
    imem_req_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (count < DEPTH_C) state_d = StReq;
      end
      StReq: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_d = StWait;
          // A stale request (already redirected) must not advance the new target
          if (!drop_q && !taken) fetch_pc_d = fetch_pc_q + INSTR_BYTES;
        end
      end
      StWait: begin
        if (imem_resp_valid) begin
          state_d = StIdle;
          drop_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (taken) begin
      fetch_pc_d = target_aligned;
      // A response landing this same cycle is dropped directly, so no pending drop
      if ((state_q == StReq) || ((state_q == StWait) && !imem_resp_valid)) drop_d = 1'b1;
    end

    // Address is latched on issue so it stays stable while REQ waits for ready
    if ((state_q == StIdle) && (state_d == StReq)) req_addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign push = resp_fire && !drop_q && !taken;
  assign pop  = instruction_valid && decode_ready;

  fetch_queue #(
    .FQ_DEPTH(FQ_DEPTH)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry('{pc: req_addr_q, instr: imem_resp_data}),
    .pop       (pop),
    .flush     (taken),
    .head      (head),
    .count     (count)
  );

  assign imem_req_addr     = req_addr_q;
  assign instruction       = head.instr;
  assign instruction_pc    = head.pc;
  assign instruction_valid = (count != '0);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory model, scoreboard of expected fetch PCs,
// and a decoupled monitor that checks every instruction the decoder consumes.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instruction, instruction_pc;
  logic        instruction_valid, decode_ready;
  logic        resolve_valid;
  logic [1:0]  next_pc_src;
  logic        alu_pc_result_zero;
  logic [31:0] alu_pc_target;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] acc_log[$];

  bit          ready_en    = 1'b1;
  int          resp_delay  = 1;
  bit          mem_pending = 1'b0;
  int          mem_wait    = 0;
  logic [31:0] mem_addr    = '0;

  instruction_fetch #(
    .RESET_PC(32'h0000_0000),
    .FQ_DEPTH(2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .decode_ready      (decode_ready),
    .resolve_valid     (resolve_valid),
    .next_pc_src       (next_pc_src),
    .alu_pc_result_zero(alu_pc_result_zero),
    .alu_pc_target     (alu_pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < acc_log.size()) return acc_log[i];
    return 'x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Instruction memory: one response resp_delay cycles after each accepted request
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_req_ready  = ready_en;
      imem_resp_valid = 1'b0;
      if (rst) begin
        mem_pending = 1'b0;
        continue;
      end
      if (mem_pending) begin
        if (mem_wait == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_addr);
          mem_pending     = 1'b0;
        end else begin
          mem_wait--;
        end
      end else if (imem_req_valid && imem_req_ready) begin
        mem_pending = 1'b1;
        mem_wait    = resp_delay - 1;
        mem_addr    = imem_req_addr;
        acc_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: every consumed instruction is compared against the scoreboard head
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && instruction_valid && decode_ready && !resolve_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, expected no delivery", instruction_pc);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", instruction_pc, e);
          check("deliver_data", instruction, mem_word(e));
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog timeout");
  end

  task automatic wait_empty(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    decode_ready = 1'b0;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: %0d instructions undelivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    resolve_valid = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    acc_log.delete();
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [1:0] src, input logic zero, input logic [31:0] tgt);
    resolve_valid      = 1'b1;
    next_pc_src        = src;
    alu_pc_result_zero = zero;
    alu_pc_target      = tgt;
  endtask

  initial begin
    int n;
    int cnt;
    rst                = 1'b1;
    decode_ready       = 1'b0;
    resolve_valid      = 1'b0;
    next_pc_src        = NEXT_PC_SRC_ALWAYS_NOT_BRANCH;
    alu_pc_result_zero = 1'b0;
    alu_pc_target      = '0;

    repeat (3) @(negedge clk);
    #3;
    check("rst_instr_valid", instruction_valid, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_instr_pc", instruction_pc, 0);

    @(negedge clk);
    rst = 1'b0;
    acc_log.delete();
    @(negedge clk);
    #3;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, 32'h0);

    // Decoder stalled: queue fills to depth and fetch stops
    repeat (15) @(negedge clk);
    #3;
    check("full_head_valid", instruction_valid, 1);
    check("full_head_pc", instruction_pc, 32'h0);
    check("full_head_data", instruction, mem_word(32'h0));
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      #3;
      if (imem_req_valid) cnt++;
    end
    check("full_no_req", cnt, 0);

    @(negedge clk);
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    decode_ready = 1'b1;
    wait_empty("seq_drain");
    check("resume_addr", log_at(2), 32'h8);

    // Taken jump while the request for 0x10 is waiting on memory
    do_reset();
    resp_delay   = 4;
    decode_ready = 1'b1;
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    wait_empty("slow_seq");
    n = 0;
    while (!(mem_pending && mem_addr == 32'h10) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_0x10_seen", (mem_pending && mem_addr == 32'h10), 1);
    redirect(NEXT_PC_SRC_ALWAYS_BRANCH, 1'b0, 32'h0000_0101);
    acc_log.delete();
    @(negedge clk);
    resolve_valid = 1'b0;
    resp_delay    = 1;
    exp_q = '{32'h100, 32'h104, 32'h108};
    decode_ready = 1'b1;
    wait_empty("jump_target");
    check("jump_first_addr", log_at(0), 32'h100);

    // Not-taken resolutions leave the full queue untouched
    repeat (12) @(negedge clk);
    #3;
    check("nt_head_before", instruction_pc, 32'h10C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) redirect(NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO, 1'b0, 32'h40);
      else if (i == 1) redirect(NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_NOT_ZERO, 1'b1, 32'h40);
      else redirect(NEXT_PC_SRC_ALWAYS_NOT_BRANCH, 1'b1, 32'h40);
      @(negedge clk);
      resolve_valid = 1'b0;
      #3;
      check("nt_valid", instruction_valid, 1);
      check("nt_pc", instruction_pc, 32'h10C);
    end

    @(negedge clk);
    redirect(NEXT_PC_SRC_BRANCH_ON_ALU_PC_RESULT_ZERO, 1'b1, 32'h40);
    @(negedge clk);
    resolve_valid = 1'b0;
    #3;
    check("beq_flush_valid", instruction_valid, 0);
    exp_q = '{32'h40, 32'h44};
    decode_ready = 1'b1;
    wait_empty("beq_target");

    // Memory stalls 5 cycles; redirect arrives in the second stalled cycle
    ready_en     = 1'b0;
    decode_ready = 1'b1;
    do_reset();
    exp_q = '{32'h200, 32'h204};
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) redirect(NEXT_PC_SRC_ALWAYS_BRANCH, 1'b0, 32'h0000_0203);
      else resolve_valid = 1'b0;
      #3;
      if (imem_req_valid && imem_req_addr == 32'h0) cnt++;
    end
    check("stall_addr_held", cnt, 5);
    @(negedge clk);
    resolve_valid = 1'b0;
    ready_en      = 1'b1;
    wait_empty("stall_target");
    check("stall_first_addr", log_at(0), 32'h0);
    check("stall_second_addr", log_at(1), 32'h200);

    // Reset in the middle of an outstanding request with a queued instruction
    resp_delay = 4;
    n = 0;
    while (!(instruction_valid && mem_pending) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mid_wait_seen", (instruction_valid && mem_pending), 1);
    rst = 1'b1;
    #3;
    check("mid_rst_instr_valid", instruction_valid, 0);
    check("mid_rst_req_valid", imem_req_valid, 0);
    check("mid_rst_instr_pc", instruction_pc, 0);
    repeat (2) @(negedge clk);
    acc_log.delete();
    exp_q.delete();
    rst        = 1'b0;
    resp_delay = 1;
    exp_q = '{32'h0, 32'h4};
    decode_ready = 1'b1;
    wait_empty("restart");
    check("restart_addr", log_at(0), 32'h0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
